hv_efuse_load_ctrl: RTL and testbench

// - Responder side of the hv control FSM efuse load handshake. On a load request, reads EFUSE_WORD_NUM words

---
 rtl/hv_efuse_load_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hv_efuse_load_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hv_efuse_load_ctrl.sv
// Efuse image loader: reads EFUSE_WORD_NUM words through a strobed read port and writes them into the register file.
// Optional checksum of the image over the last word is enabled by defining EFUSE_LOAD_CHK_EN.
module hv_efuse_load_ctrl #(
  parameter int EFUSE_WORD_NUM = 8,
  parameter int EFUSE_DATA_W   = 8,
  parameter int EFUSE_ADDR_W   = 3,
  parameter int STRB_CYC       = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_efuse_load_req,
  output logic                    o_efuse_load_done,
  output logic                    o_efuse_busy,
  output logic                    o_efuse_rd_en,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
  input  logic [EFUSE_DATA_W-1:0] i_efuse_rdata,
  output logic                    o_reg_wr_en,
  output logic [EFUSE_ADDR_W-1:0] o_reg_wr_addr,
  output logic [EFUSE_DATA_W-1:0] o_reg_wr_data,
  output logic                    o_efuse_vld,
  output logic                    o_efuse_chk_err
);

  localparam int SW = (STRB_CYC > 1) ? $clog2(STRB_CYC) : 1;
  localparam logic [SW-1:0]           STRB_LAST = SW'(STRB_CYC - 1);
  localparam logic [EFUSE_ADDR_W-1:0] WORD_LAST = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    STRB  = 3'd2,
    WR    = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [EFUSE_ADDR_W-1:0] idx_q, idx_d;
  logic [SW-1:0]           scnt_q, scnt_d;
  logic [EFUSE_DATA_W-1:0] cap_q, cap_d;
  logic                    vld_q, vld_d;

  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    rd_en_q, rd_en_d;
  logic                    wr_en_q, wr_en_d;
  logic [EFUSE_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [EFUSE_DATA_W-1:0] wr_data_q, wr_data_d;

`ifdef EFUSE_LOAD_CHK_EN
  logic [EFUSE_DATA_W-1:0] acc_q, acc_d;
  logic                    err_q, err_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      scnt_q    <= '0;
      cap_q     <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef EFUSE_LOAD_CHK_EN
      acc_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      scnt_q    <= scnt_d;
      cap_q     <= cap_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef EFUSE_LOAD_CHK_EN
      acc_q     <= acc_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    scnt_d  = scnt_q;
    cap_d   = cap_q;
    vld_d   = vld_q;
`ifdef EFUSE_LOAD_CHK_EN
    acc_d   = acc_q;
    err_d   = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_efuse_load_req) begin
          idx_d   = '0;
`ifdef EFUSE_LOAD_CHK_EN
          acc_d   = '0;
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        scnt_d  = '0;
        state_d = STRB;
      end
      STRB: begin
        // Read data is taken on the final strobe cycle, when the macro output has settled longest.
        if (scnt_q == STRB_LAST) begin
          cap_d   = i_efuse_rdata;
`ifdef EFUSE_LOAD_CHK_EN
          if (idx_q != WORD_LAST) acc_d = acc_q ^ i_efuse_rdata;
`endif
          state_d = WR;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      WR: begin
        if (idx_q == WORD_LAST) begin
          state_d = CHK;
        end else begin
          idx_d   = idx_q + EFUSE_ADDR_W'(1);
          state_d = SETUP;
        end
      end
      CHK: begin
`ifdef EFUSE_LOAD_CHK_EN
        vld_d = (acc_q == cap_q);
        err_d = (acc_q != cap_q);
`else
        vld_d = 1'b1;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (!i_efuse_load_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every output is a flop.
    busy_d    = (state_d == SETUP) || (state_d == STRB) || (state_d == WR) || (state_d == CHK);
    rd_en_d   = (state_d == STRB);
    wr_en_d   = (state_d == WR);
    done_d    = (state_d == DONE);
    wr_addr_d = (state_d == WR) ? idx_d : '0;
    wr_data_d = (state_d == WR) ? cap_d : '0;
  end

  assign o_efuse_load_done = done_q;
  assign o_efuse_busy      = busy_q;
  assign o_efuse_rd_en     = rd_en_q;
  assign o_efuse_addr      = idx_q;
  assign o_reg_wr_en       = wr_en_q;
  assign o_reg_wr_addr     = wr_addr_q;
  assign o_reg_wr_data     = wr_data_q;
  assign o_efuse_vld       = vld_q;
`ifdef EFUSE_LOAD_CHK_EN
  assign o_efuse_chk_err   = err_q;
`else
  assign o_efuse_chk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_hv_efuse_load_ctrl.sv
// Bench for hv_efuse_load_ctrl: two instances (strobe 4 and strobe 1) checked every cycle against a timeline model.
module tb_hv_efuse_load_ctrl;

  localparam int N = 8;

  logic       clk;
  logic       rst;
  logic       req     [2];
  logic       done_o  [2];
  logic       busy_o  [2];
  logic       rd_o    [2];
  logic [2:0] addr_o  [2];
  logic [7:0] rdata   [2];
  logic       wr_o    [2];
  logic [2:0] wa_o    [2];
  logic [7:0] wd_o    [2];
  logic       vld_o   [2];
  logic       err_o   [2];

  logic [7:0] img [N];
  logic [7:0] junk;

  logic       exp_done [2];
  logic       exp_busy [2];
  logic       exp_rd   [2];
  logic [2:0] exp_addr [2];
  logic       exp_wr   [2];
  logic [2:0] exp_wa   [2];
  logic [7:0] exp_wd   [2];
  logic       exp_vld  [2];
  logic       exp_err  [2];

  int  tests;
  int  errs;
  bit  cmp_on;

  hv_efuse_load_ctrl #(.EFUSE_WORD_NUM(N), .EFUSE_DATA_W(8), .EFUSE_ADDR_W(3), .STRB_CYC(4)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_efuse_load_req(req[0]), .o_efuse_load_done(done_o[0]),
    .o_efuse_busy(busy_o[0]), .o_efuse_rd_en(rd_o[0]), .o_efuse_addr(addr_o[0]),
    .i_efuse_rdata(rdata[0]), .o_reg_wr_en(wr_o[0]), .o_reg_wr_addr(wa_o[0]),
    .o_reg_wr_data(wd_o[0]), .o_efuse_vld(vld_o[0]), .o_efuse_chk_err(err_o[0]));

  hv_efuse_load_ctrl #(.EFUSE_WORD_NUM(N), .EFUSE_DATA_W(8), .EFUSE_ADDR_W(3), .STRB_CYC(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_efuse_load_req(req[1]), .o_efuse_load_done(done_o[1]),
    .o_efuse_busy(busy_o[1]), .o_efuse_rd_en(rd_o[1]), .o_efuse_addr(addr_o[1]),
    .i_efuse_rdata(rdata[1]), .o_reg_wr_en(wr_o[1]), .o_reg_wr_addr(wa_o[1]),
    .o_reg_wr_data(wd_o[1]), .o_efuse_vld(vld_o[1]), .o_efuse_chk_err(err_o[1]));

  // Efuse macro: real data only while strobed, noise otherwise.
  assign rdata[0] = rd_o[0] ? img[addr_o[0]] : junk;
  assign rdata[1] = rd_o[1] ? img[addr_o[1]] : junk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) junk <= 8'($urandom);

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", nm, inst, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        chk("done",    i, 32'(done_o[i]), 32'(exp_done[i]));
        chk("busy",    i, 32'(busy_o[i]), 32'(exp_busy[i]));
        chk("rd_en",   i, 32'(rd_o[i]),   32'(exp_rd[i]));
        chk("addr",    i, 32'(addr_o[i]), 32'(exp_addr[i]));
        chk("wr_en",   i, 32'(wr_o[i]),   32'(exp_wr[i]));
        chk("wr_addr", i, 32'(wa_o[i]),   32'(exp_wa[i]));
        chk("wr_data", i, 32'(wd_o[i]),   32'(exp_wd[i]));
        chk("vld",     i, 32'(vld_o[i]),  32'(exp_vld[i]));
        chk("chk_err", i, 32'(err_o[i]),  32'(exp_err[i]));
      end
    end
  end

  task automatic clear_exp(input int i);
    exp_done[i] = 1'b0; exp_busy[i] = 1'b0; exp_rd[i] = 1'b0; exp_addr[i] = '0;
    exp_wr[i] = 1'b0; exp_wa[i] = '0; exp_wd[i] = '0; exp_vld[i] = 1'b0; exp_err[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One load on instance i with strobe width s. drop_at: cycle at which req falls (0 = hold
  // 'hold' cycles of done). rst_at: cycle at which reset is asserted (0 = never).
  task automatic run_load(input int i, input int s, input int drop_at, input int hold,
                          input int rst_at, output int done_k);
    int total, k, w, p;
    logic sampled;
    logic [7:0] x;
    total  = N * (s + 2) + 2;
    done_k = -1;
    k      = 0;
    req[i] = 1'b1;
    forever begin
      sampled = req[i];
      @(posedge clk); #1;
      k++;
      if (rst) begin
        for (int j = 0; j < 2; j++) clear_exp(j);
        rst    = 1'b0;
        req[i] = 1'b0;
        return;
      end
      if (k <= total - 2) begin
        w = (k - 1) / (s + 2);
        p = (k - 1) % (s + 2);
        exp_busy[i] = 1'b1;
        exp_addr[i] = 3'(w);
        exp_rd[i]   = (p >= 1) && (p <= s);
        exp_wr[i]   = (p == s + 1);
        exp_wa[i]   = exp_wr[i] ? 3'(w) : 3'd0;
        exp_wd[i]   = exp_wr[i] ? img[w] : 8'd0;
      end else if (k == total - 1) begin
        exp_busy[i] = 1'b1; exp_rd[i] = 1'b0; exp_wr[i] = 1'b0;
        exp_wa[i] = '0; exp_wd[i] = '0; exp_addr[i] = 3'(N - 1);
      end else if (k == total) begin
        exp_busy[i] = 1'b0;
        exp_done[i] = 1'b1;
`ifdef EFUSE_LOAD_CHK_EN
        x = 8'd0;
        for (int j = 0; j < N - 1; j++) x = x ^ img[j];
        exp_vld[i] = (x == img[N-1]);
        exp_err[i] = (x != img[N-1]);
`else
        exp_vld[i] = 1'b1;
        exp_err[i] = 1'b0;
`endif
      end else if (!sampled) begin
        exp_done[i] = 1'b0;
        return;
      end
      if (done_o[i] === 1'b1 && done_k < 0) done_k = k;
      if (rst_at == k) rst = 1'b1;
      if (drop_at == k) req[i] = 1'b0;
      if (drop_at == 0 && k == total + hold - 1) req[i] = 1'b0;
    end
  endtask

  task automatic default_image();
    for (int j = 0; j < N - 1; j++) img[j] = 8'(17 * (j + 1));
    img[N-1] = 8'h00;
  endtask

  initial begin
    int dk, inst, s, total, drop;
    logic [7:0] x;
    tests  = 0;
    errs   = 0;
    cmp_on = 1'b0;
    rst    = 1'b1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    for (int j = 0; j < 2; j++) clear_exp(j);
    default_image();
    @(posedge clk); #1;
    cmp_on = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Good image, strobe 4: done exactly 50 cycles after req is seen.
    run_load(0, 4, 0, 1, 0, dk);
    chk("lat_s4", 0, 32'(dk), 32'd50);
    chk("vld_good", 0, 32'(vld_o[0]), 32'd1);
    chk("err_good", 0, 32'(err_o[0]), 32'd0);
    idle(3);

    // Corrupted checksum word.
    img[N-1] = 8'h5A;
    run_load(0, 4, 0, 1, 0, dk);
`ifdef EFUSE_LOAD_CHK_EN
    chk("vld_bad", 0, 32'(vld_o[0]), 32'd0);
    chk("err_bad", 0, 32'(err_o[0]), 32'd1);
`else
    chk("vld_bad", 0, 32'(vld_o[0]), 32'd1);
`endif
    idle(2);

    // Strobe width 1 instance.
    default_image();
    run_load(1, 1, 0, 1, 0, dk);
    chk("lat_s1", 1, 32'(dk), 32'd26);
    idle(2);

    // req dropped early: load completes, done pulses once, no restart.
    run_load(0, 4, 10, 1, 0, dk);
    idle(6);

    // done held for 5 cycles, then a second load only after req rises again.
    run_load(0, 4, 0, 5, 0, dk);
    idle(4);
    run_load(0, 4, 0, 1, 0, dk);
    idle(2);

    // Reset during the first strobe cycle of word 3, then a clean reload.
    run_load(0, 4, 0, 1, 3 * 6 + 2, dk);
    idle(3);
    run_load(0, 4, 0, 1, 0, dk);
    idle(2);

    // Randomized images, instances and req drop points.
    for (int r = 0; r < 16; r++) begin
      inst = int'($urandom_range(0, 1));
      s    = (inst == 0) ? 4 : 1;
      total = N * (s + 2) + 2;
      x = 8'd0;
      for (int j = 0; j < N - 1; j++) begin
        img[j] = 8'($urandom);
        x = x ^ img[j];
      end
      img[N-1] = ($urandom_range(0, 1) == 1) ? x : 8'($urandom);
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, total)) : 0;
      run_load(inst, s, drop, int'($urandom_range(1, 4)), 0, dk);
      idle(int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
